// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake and memory-side bus of mem_access_ctrl.
// The slave modport is the controller's view; master is the client/memory side.
interface mem_access_ctrl_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DinLENGTH = 32
);
  logic                 Req_Valid;
  logic                 Req_Ready;
  logic                 Req_RW;
  logic [WIDTH-1:0]     Req_Addr;
  logic [DinLENGTH-1:0] Req_Data;
  logic                 Rsp_Valid;
  logic                 Rsp_Ready;
  logic                 Rsp_RW;
  logic [DinLENGTH-1:0] Rsp_Data;
  logic                 Mem_Valid;
  logic                 Mem_R_W;
  logic [WIDTH-1:0]     Mem_Addr;
  logic [DinLENGTH-1:0] Mem_Din;
  logic [DinLENGTH-1:0] Mem_Dout;

  modport slave (
    input  Req_Valid, Req_RW, Req_Addr, Req_Data, Rsp_Ready, Mem_Dout,
    output Req_Ready, Rsp_Valid, Rsp_RW, Rsp_Data, Mem_Valid, Mem_R_W, Mem_Addr, Mem_Din
  );

  modport master (
    output Req_Valid, Req_RW, Req_Addr, Req_Data, Rsp_Ready, Mem_Dout,
    input  Req_Ready, Rsp_Valid, Rsp_RW, Rsp_Data, Mem_Valid, Mem_R_W, Mem_Addr, Mem_Din
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding memory access controller: accepts one request, issues one
// memory cycle, and holds the response until the client takes it.
module mem_access_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DinLENGTH = 32
) (
  input  logic                Clk,
  input  logic                Reset,
  mem_access_ctrl_if.slave    bus,
  output logic [15:0]         Txn_Count
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StRespond} state_e;

  state_e               state_q, state_d;
  logic                 mem_valid_q, mem_valid_d;
  logic                 mem_rw_q, mem_rw_d;
  logic [WIDTH-1:0]     mem_addr_q, mem_addr_d;
  logic [DinLENGTH-1:0] mem_din_q, mem_din_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_rw_q, rsp_rw_d;
  logic [DinLENGTH-1:0] rsp_data_q, rsp_data_d;
  logic [15:0]          txn_count_q, txn_count_d;

  // Mem_Addr/Mem_Din double as the request latch; Mem_R_W is only valid in
  // ISSUE, which is exactly when the write/read branch is decided.
  always_comb begin
    state_d     = state_q;
    mem_valid_d = 1'b0;
    mem_rw_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rw_d    = rsp_rw_q;
    rsp_data_d  = rsp_data_q;
    txn_count_d = txn_count_q;
    unique case (state_q)
      StIdle: begin
        if (bus.Req_Valid) begin
          mem_valid_d = 1'b1;
          mem_rw_d    = bus.Req_RW;
          mem_addr_d  = bus.Req_Addr;
          mem_din_d   = bus.Req_Data;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (mem_rw_q) begin
          rsp_valid_d = 1'b1;
          rsp_rw_d    = 1'b1;
          rsp_data_d  = mem_din_q;
          state_d     = StRespond;
        end else begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        rsp_valid_d = 1'b1;
        rsp_rw_d    = 1'b0;
        rsp_data_d  = bus.Mem_Dout;
        state_d     = StRespond;
      end
      StRespond: begin
        if (bus.Rsp_Ready) begin
          rsp_valid_d = 1'b0;
          rsp_rw_d    = 1'b0;
          txn_count_d = txn_count_q + 16'd1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rw_q    <= 1'b0;
      rsp_data_q  <= '0;
      txn_count_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rw_q    <= rsp_rw_d;
      rsp_data_q  <= rsp_data_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign bus.Req_Ready = (state_q == StIdle);
  assign bus.Mem_Valid = mem_valid_q;
  assign bus.Mem_R_W   = mem_rw_q;
  assign bus.Mem_Addr  = mem_addr_q;
  assign bus.Mem_Din   = mem_din_q;
  assign bus.Rsp_Valid = rsp_valid_q;
  assign bus.Rsp_RW    = rsp_rw_q;
  assign bus.Rsp_Data  = rsp_data_q;
  assign Txn_Count     = txn_count_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with a behavioural memory; responses are checked by
// a scoreboard monitor. The transaction counter is preloaded to keep the wrap test short.
module tb_mem_access_ctrl;

  logic        Clk;
  logic        Reset;
  logic [15:0] Txn_Count;

  mem_access_ctrl_if #(.WIDTH(8), .DinLENGTH(32)) bus ();

  mem_access_ctrl #(.WIDTH(8), .DinLENGTH(32)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .Txn_Count (Txn_Count)
  );

  typedef struct {
    logic        rw;
    logic [31:0] data;
    logic [15:0] cnt;
    int          first_cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks    = 0;
  int          failures  = 0;
  int          cyc       = 0;
  int          mem_pulses = 0;
  logic        prev_mv   = 1'b0;
  logic        rsp_seen  = 1'b0;
  logic [15:0] exp_count = 16'd0;
  logic [31:0] mem [256];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  // Memory model: acts on posedge with Valid; read data visible next cycle.
  always @(posedge Clk) begin
    if (bus.Mem_Valid) begin
      if (bus.Mem_R_W) mem[bus.Mem_Addr] <= bus.Mem_Din;
      else             bus.Mem_Dout <= mem[bus.Mem_Addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor and Mem_Valid spacing check.
  always @(negedge Clk) begin
    if (Reset) begin
      rsp_seen = 1'b0;
      prev_mv  = 1'b0;
    end else begin
      if (bus.Mem_Valid) begin
        mem_pulses++;
        checks++;
        if (prev_mv) begin
          failures++;
          $display("FAIL mem_valid_consecutive got=1 exp=0 (t=%0t)", $time);
        end
      end
      prev_mv = bus.Mem_Valid;
      if (bus.Rsp_Valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp got=Rsp_Valid exp=none (t=%0t)", $time);
        end else begin
          mon_e = sb[0];
          if (!rsp_seen) begin
            chk("rsp_latency_cycle", cyc, mon_e.first_cyc);
            chk("rsp_rw", {31'd0, bus.Rsp_RW}, {31'd0, mon_e.rw});
            chk("rsp_txn_count", {16'd0, Txn_Count}, {16'd0, mon_e.cnt});
            rsp_seen = 1'b1;
          end
          chk("rsp_data", bus.Rsp_Data, mon_e.data);
          if (bus.Rsp_Ready) begin
            void'(sb.pop_front());
            rsp_seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic do_req(input logic rw, input logic [7:0] a, input logic [31:0] d,
                        input logic [31:0] exp_data);
    exp_t e;
    int   n = 0;
    @(posedge Clk); #1;
    while (!bus.Req_Ready && n < 50) begin
      @(posedge Clk); #1;
      n++;
    end
    if (!bus.Req_Ready) begin
      checks++;
      failures++;
      $display("FAIL req_ready_timeout got=0 exp=1 (t=%0t)", $time);
    end else begin
      bus.Req_Valid = 1'b1;
      bus.Req_RW    = rw;
      bus.Req_Addr  = a;
      bus.Req_Data  = d;
      @(posedge Clk); #1;
      e.rw        = rw;
      e.data      = exp_data;
      e.cnt       = exp_count;
      e.first_cyc = cyc + (rw ? 1 : 2);
      sb.push_back(e);
      exp_count++;
      bus.Req_Valid = 1'b0;
      @(negedge Clk);
      chk("issue_mem_valid", {31'd0, bus.Mem_Valid}, 32'd1);
      chk("issue_mem_rw", {31'd0, bus.Mem_R_W}, {31'd0, rw});
      chk("issue_mem_addr", {24'd0, bus.Mem_Addr}, {24'd0, a});
      if (rw) chk("issue_mem_din", bus.Mem_Din, d);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout got=%0d exp=0 pending (t=%0t)", sb.size(), $time);
      sb.delete();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, {31'd0, bus.Req_Ready}, 32'd1);
    chk({tag, "_mem_valid"}, {31'd0, bus.Mem_Valid}, 32'd0);
    chk({tag, "_mem_rw"}, {31'd0, bus.Mem_R_W}, 32'd0);
    chk({tag, "_mem_addr"}, {24'd0, bus.Mem_Addr}, 32'd0);
    chk({tag, "_mem_din"}, bus.Mem_Din, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, bus.Rsp_Valid}, 32'd0);
    chk({tag, "_rsp_rw"}, {31'd0, bus.Rsp_RW}, 32'd0);
    chk({tag, "_rsp_data"}, bus.Rsp_Data, 32'd0);
    chk({tag, "_txn_count"}, {16'd0, Txn_Count}, 32'd0);
  endtask

  initial begin
    int p;
    int n;
    Reset         = 1'b1;
    bus.Req_Valid = 1'b0;
    bus.Req_RW    = 1'b0;
    bus.Req_Addr  = 8'h00;
    bus.Req_Data  = 32'h0;
    bus.Rsp_Ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk_all_zero("reset");

    // Write then read back at 0x05.
    do_req(1'b1, 8'h05, 32'hDEADBEEF, 32'hDEADBEEF);
    wait_done();
    chk("txn_after_write", {16'd0, Txn_Count}, 32'd1);
    do_req(1'b0, 8'h05, 32'h0, 32'hDEADBEEF);
    wait_done();
    chk("txn_after_read", {16'd0, Txn_Count}, 32'd2);

    // Backpressured read with a competing request that must be ignored.
    bus.Rsp_Ready = 1'b0;
    do_req(1'b0, 8'h05, 32'h0, 32'hDEADBEEF);
    n = 0;
    while (!bus.Rsp_Valid && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("stall_rsp_arrived", {31'd0, bus.Rsp_Valid}, 32'd1);
    p = mem_pulses;
    @(posedge Clk); #1;
    bus.Req_Valid = 1'b1;
    bus.Req_RW    = 1'b1;
    bus.Req_Addr  = 8'h33;
    bus.Req_Data  = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("stall_rsp_valid", {31'd0, bus.Rsp_Valid}, 32'd1);
      chk("stall_rsp_data", bus.Rsp_Data, 32'hDEADBEEF);
      chk("stall_req_ready", {31'd0, bus.Req_Ready}, 32'd0);
    end
    @(posedge Clk); #1;
    bus.Req_Valid = 1'b0;
    bus.Rsp_Ready = 1'b1;
    chk("stall_no_extra_pulse", mem_pulses, p);
    wait_done();
    chk("txn_after_stall", {16'd0, Txn_Count}, 32'd3);

    // Boundary address.
    do_req(1'b1, 8'hFF, 32'h12345678, 32'h12345678);
    wait_done();
    do_req(1'b0, 8'hFF, 32'h0, 32'h12345678);
    wait_done();
    chk("txn_after_boundary", {16'd0, Txn_Count}, 32'd5);

    // Reset while the read sits in CAPTURE.
    do_req(1'b0, 8'h05, 32'h0, 32'hDEADBEEF);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    sb.delete();
    exp_count = 16'd0;
    p = mem_pulses;
    @(negedge Clk);
    chk_all_zero("capreset");
    repeat (4) @(negedge Clk);
    chk("capreset_no_pulse", mem_pulses, p);
    chk("capreset_no_rsp", {31'd0, bus.Rsp_Valid}, 32'd0);
    do_req(1'b0, 8'h05, 32'h0, 32'hDEADBEEF);
    wait_done();
    chk("txn_after_capreset", {16'd0, Txn_Count}, 32'd1);

    // Counter wrap from a preloaded value.
    @(posedge Clk); #1;
    force dut.txn_count_q = 16'hFFFE;
    @(posedge Clk); #1;
    release dut.txn_count_q;
    exp_count = 16'hFFFE;
    @(negedge Clk);
    chk("preload_count", {16'd0, Txn_Count}, 32'h0000FFFE);
    do_req(1'b1, 8'h10, 32'h0000AAAA, 32'h0000AAAA);
    wait_done();
    chk("txn_ffff", {16'd0, Txn_Count}, 32'h0000FFFF);
    do_req(1'b1, 8'h11, 32'h5555AAAA, 32'h5555AAAA);
    wait_done();
    chk("txn_wrap", {16'd0, Txn_Count}, 32'h00000000);

    repeat (3) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameters: WIDTH, 8, address bits; DinLENGTH, 32, data bits.
REQ-002 SHALL have ports (name  direction  width  meaning):
- Clk  in  1  single clock, all logic on posedge.
- Reset  in  1  synchronous, active-high.
- Req_Valid  in  1  client request present.
- Req_Ready  out  1  controller accepts a request this cycle.
- Req_RW  in  1  1 = write, 0 = read.
- Req_Addr  in  WIDTH  request address.
- Req_Data  in  DinLENGTH  write data.
- Rsp_Valid  out  1  response present.
- Rsp_Ready  in  1  client takes the response.
- Rsp_RW  out  1  echo of the request type.
- Rsp_Data  out  DinLENGTH  read data; written data for a write.
- Mem_Valid  out  1  to memory Valid.
- Mem_R_W  out  1  to memory R_W.
- Mem_Addr  out  WIDTH  to memory Addr.
- Mem_Din  out  DinLENGTH  to memory Din.
- Mem_Dout  in  DinLENGTH  from memory Dout.
- Txn_Count  out  16  completed transactions.
REQ-003 SHALL use one clock (Clk) and a synchronous, active-high reset (Reset); no other clock or asynchronous input.

Function
REQ-004 SHALL drive a memory that acts on a posedge when Valid=1: a write stores Din; a read updates Dout, and that value is valid from the next cycle.
REQ-005 SHALL implement FSM states IDLE, ISSUE, CAPTURE, RESPOND.
REQ-006 IDLE: Req_Ready=1 and all other control outputs 0. On Req_Valid=1, latch Req_RW, Req_Addr and Req_Data, then go to ISSUE.
REQ-007 Req_Ready SHALL be 1 only in IDLE. Requests offered in other states are ignored and not latched.
REQ-008 ISSUE: Mem_Valid=1 for exactly one cycle, with Mem_R_W, Mem_Addr and Mem_Din set to the latched values. Go to RESPOND for a write, CAPTURE for a read.
REQ-009 CAPTURE: Mem_Valid=0. Register Mem_Dout into Rsp_Data at the end of this cycle, then go to RESPOND.
REQ-010 On a write, Rsp_Data SHALL equal the latched write data when entering RESPOND.
REQ-011 RESPOND: Rsp_Valid=1, with Rsp_RW and Rsp_Data held stable until Rsp_Ready=1. On the Rsp_Valid&Rsp_Ready cycle, go to IDLE and add 1 to Txn_Count.
REQ-012 Latency, with acceptance at edge 0:
- Mem_Valid high in cycle 1.
- Write: Rsp_Valid from cycle 2.
- Read: Rsp_Valid from cycle 3.
- Minimum spacing between accepted requests: 3 cycles (write), 4 cycles (read).
REQ-013 Txn_Count SHALL wrap from 16'hFFFF to 16'h0000 without stalling.
REQ-014 Mem_Valid SHALL never be high in two consecutive cycles. There SHALL be at most one outstanding transaction.
REQ-015 Mem_Addr and Mem_Din SHALL hold their last values outside ISSUE. Mem_R_W SHALL be 0 outside ISSUE.
REQ-016 All outputs SHALL be registered, except Req_Ready, which may be decoded from state.
REQ-017 An address at the boundary ((1<<WIDTH)-1) SHALL pass unmodified. There SHALL be no address arithmetic.

Reset
REQ-018 Reset=1 at a posedge SHALL force:
- FSM to IDLE.
- Mem_Valid, Mem_R_W, Rsp_Valid, Rsp_RW to 0.
- Mem_Addr, Mem_Din, Rsp_Data, Txn_Count to 0.
REQ-019 Reset SHALL override all other inputs in that cycle. Reset in any state SHALL abandon the transaction: no Mem_Valid pulse afterwards and no response.
REQ-020 The block SHALL NOT drive the memory's Reset. The memory's contents are independent of this block's reset.

Verification
REQ-021 SHALL be verified with the block connected to the memory model (WIDTH=8, DinLENGTH=32) in these directed scenarios:
- Write Addr=8'h05, Data=32'hDEADBEEF, with Rsp_Ready=1 -> one Mem_Valid pulse with Mem_R_W=1; Rsp_Valid in cycle 2 with Rsp_RW=1 and Rsp_Data=32'hDEADBEEF; Txn_Count=1.
- Then read Addr=8'h05 -> Mem_Valid pulse with Mem_R_W=0; Rsp_Valid in cycle 3 with Rsp_Data=32'hDEADBEEF; Txn_Count=2.
- Read with Rsp_Ready held 0 for 5 cycles -> Rsp_Valid and Rsp_Data stable; Req_Ready=0; a concurrent Req_Valid does not cause a second Mem_Valid.
- Write then read Addr=8'hFF, Data=32'h12345678 -> Mem_Addr=8'hFF on both; read returns 32'h12345678.
- Reset asserted in CAPTURE -> next cycle all outputs 0, IDLE, Req_Ready=1, no response; a following read returns the memory's contents.
- Txn_Count preloaded via 65535 transactions, then 1 more -> Txn_Count=16'h0000.
